// File: rtl/snd_dma_pkg.sv
// Shared encodings for the sound DMA sequencer: register selects, CTRL bits
// and the arbiter FSM state type.
package snd_dma_pkg;

  localparam logic [1:0] SEL_CTRL = 2'd0;
  localparam logic [1:0] SEL_BASE = 2'd1;
  localparam logic [1:0] SEL_TOP  = 2'd2;
  localparam logic [1:0] SEL_CUR  = 2'd3;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_RPT = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

endpackage

// File: rtl/snd_dma_chan.sv
// One sound DMA channel: CTRL/BASE/TOP/CUR registers, frame-end detection
// and the one-cycle frame-end pulse.
module snd_dma_chan
  import snd_dma_pkg::*;
#(
  parameter int AW = 21
)(
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr_ctrl,
  input  logic          i_wr_base,
  input  logic          i_wr_top,
  input  logic [AW-1:0] i_wdata,
  input  logic          i_owns,
  input  logic          i_grant,
  output logic          o_enable,
  output logic          o_repeat,
  output logic          o_active,
  output logic          o_sint,
  output logic [AW-1:0] o_base,
  output logic [AW-1:0] o_top,
  output logic [AW-1:0] o_cur
);

  logic          r_enable;
  logic          r_repeat;
  logic          r_active;
  logic          r_sint;
  logic [AW-1:0] r_base;
  logic [AW-1:0] r_top;
  logic [AW-1:0] r_cur;
  logic [AW:0]   w_cur_inc;
  logic          w_frame_end;

  // One extra bit so CUR = all-ones compares as past any TOP.
  assign w_cur_inc   = {1'b0, r_cur} + (AW+1)'(1);
  assign w_frame_end = i_grant && (w_cur_inc >= {1'b0, r_top});

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_enable <= 1'b0;
      r_repeat <= 1'b0;
      r_active <= 1'b0;
      r_sint   <= 1'b0;
      r_base   <= '0;
      r_top    <= '0;
      r_cur    <= '0;
    end else begin
      r_sint <= w_frame_end;
      if (i_wr_base) r_base <= i_wdata;
      if (i_wr_top)  r_top  <= i_wdata;
      if (i_wr_ctrl) begin
        // A CTRL write overrides any same-edge grant bookkeeping.
        r_enable <= i_wdata[CTRL_EN];
        r_repeat <= i_wdata[CTRL_RPT];
        if (i_wdata[CTRL_EN]) begin
          r_cur    <= r_base;
          r_active <= 1'b1;
        end else if (!i_owns || i_grant) begin
          r_active <= 1'b0;
        end
      end else if (i_grant) begin
        if (w_frame_end && r_repeat) begin
          r_cur <= r_base;
        end else begin
          r_cur <= w_cur_inc[AW-1:0];
        end
        if (w_frame_end && !r_repeat) begin
          r_enable <= 1'b0;
          r_active <= 1'b0;
        end
        // Disabled while owning the bus: finish this word, then stop.
        if (!r_enable) r_active <= 1'b0;
      end
    end
  end

  assign o_enable = r_enable;
  assign o_repeat = r_repeat;
  assign o_active = r_active;
  assign o_sint   = r_sint;
  assign o_base   = r_base;
  assign o_top    = r_top;
  assign o_cur    = r_cur;

endmodule

// File: rtl/snd_dma_seq.sv
// Sound DMA sequencer: NCH channels sharing one bus through a round-robin
// arbiter; bus_req holds until bus_gnt completes the word transfer.
module snd_dma_seq
  import snd_dma_pkg::*;
#(
  parameter  int NCH = 2,
  parameter  int AW  = 21,
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1
)(
  input  logic           clk32,
  input  logic           por,
  input  logic           clk_en,
  input  logic           reg_wr,
  input  logic [CW-1:0]  reg_ch,
  input  logic [1:0]     reg_sel,
  input  logic [AW-1:0]  reg_wdata,
  output logic [AW-1:0]  reg_rdata,
  input  logic [NCH-1:0] sreq,
  output logic           bus_req,
  input  logic           bus_gnt,
  output logic [AW-1:0]  bus_addr,
  output logic [CW-1:0]  bus_ch,
  output logic [NCH-1:0] sint,
  output logic [NCH-1:0] active
);

  state_t         r_state;
  state_t         w_next;
  logic [CW-1:0]  r_owner;
  logic [CW-1:0]  r_rr;
  logic [CW-1:0]  w_sel;
  logic           w_found;
  int             w_dist;
  int             w_best;
  logic [NCH-1:0] w_enable;
  logic [NCH-1:0] w_repeat;
  logic [NCH-1:0] w_elig;
  logic [NCH-1:0] w_owns;
  logic [NCH-1:0] w_grant;
  logic [NCH-1:0] w_wr_ctrl;
  logic [NCH-1:0] w_wr_base;
  logic [NCH-1:0] w_wr_top;
  logic [NCH-1:0] w_clr;
  logic [AW-1:0]  w_base [NCH];
  logic [AW-1:0]  w_top  [NCH];
  logic [AW-1:0]  w_cur  [NCH];

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    assign w_owns[gi]    = (r_state == ST_REQ) && (r_owner == CW'(gi));
    assign w_grant[gi]   = w_owns[gi] && bus_gnt;
    assign w_wr_ctrl[gi] = reg_wr && (reg_ch == CW'(gi)) && (reg_sel == SEL_CTRL);
    assign w_wr_base[gi] = reg_wr && (reg_ch == CW'(gi)) && (reg_sel == SEL_BASE);
    assign w_wr_top[gi]  = reg_wr && (reg_ch == CW'(gi)) && (reg_sel == SEL_TOP);
    assign w_clr[gi]     = w_wr_ctrl[gi] && !reg_wdata[CTRL_EN];

    snd_dma_chan #(.AW(AW)) u_chan (
      .i_clk     (clk32),
      .i_rst     (por),
      .i_wr_ctrl (w_wr_ctrl[gi]),
      .i_wr_base (w_wr_base[gi]),
      .i_wr_top  (w_wr_top[gi]),
      .i_wdata   (reg_wdata),
      .i_owns    (w_owns[gi]),
      .i_grant   (w_grant[gi]),
      .o_enable  (w_enable[gi]),
      .o_repeat  (w_repeat[gi]),
      .o_active  (active[gi]),
      .o_sint    (sint[gi]),
      .o_base    (w_base[gi]),
      .o_top     (w_top[gi]),
      .o_cur     (w_cur[gi])
    );
  end

  // A channel being disabled on this very edge must not win the arbitration.
  assign w_elig = active & sreq & ~w_clr;

  // Round-robin: pick the eligible channel closest after the last one served.
  always_comb begin
    w_sel  = '0;
    w_best = NCH;
    w_dist = 0;
    for (int i = 0; i < NCH; i++) begin
      w_dist = i - int'(r_rr) - 1;
      if (w_dist < 0) w_dist = w_dist + NCH;
      if (w_elig[i] && (w_dist < w_best)) begin
        w_best = w_dist;
        w_sel  = CW'(i);
      end
    end
    w_found = (w_best < NCH);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (clk_en && w_found) w_next = ST_REQ;
      ST_REQ:  if (bus_gnt) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk32 or posedge por) begin
    if (por) begin
      r_state <= ST_IDLE;
      r_owner <= '0;
      r_rr    <= CW'(NCH - 1);
    end else begin
      r_state <= w_next;
      if ((r_state == ST_IDLE) && clk_en && w_found) r_owner <= w_sel;
      if ((r_state == ST_REQ) && bus_gnt) r_rr <= r_owner;
    end
  end

  always_comb begin
    bus_req   = (r_state == ST_REQ);
    bus_ch    = bus_req ? r_owner : '0;
    bus_addr  = '0;
    reg_rdata = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_owns[i]) bus_addr = w_cur[i];
      if (reg_ch == CW'(i)) begin
        case (reg_sel)
          SEL_CTRL: reg_rdata = AW'({w_repeat[i], w_enable[i]});
          SEL_BASE: reg_rdata = w_base[i];
          SEL_TOP:  reg_rdata = w_top[i];
          default:  reg_rdata = w_cur[i];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_snd_dma_seq.sv
// Bench for snd_dma_seq (NCH=2, AW=21): directed vector table, hand-written
// corner sequences, then random traffic against a transaction-level model.
module tb_snd_dma_seq;

  localparam int NCH = 2;
  localparam int AW  = 21;
  localparam int CW  = 1;

  logic           clk32;
  logic           por;
  logic           clk_en;
  logic           reg_wr;
  logic [CW-1:0]  reg_ch;
  logic [1:0]     reg_sel;
  logic [AW-1:0]  reg_wdata;
  logic [AW-1:0]  reg_rdata;
  logic [NCH-1:0] sreq;
  logic           bus_req;
  logic           bus_gnt;
  logic [AW-1:0]  bus_addr;
  logic [CW-1:0]  bus_ch;
  logic [NCH-1:0] sint;
  logic [NCH-1:0] active;

  int n_vec = 0;
  int n_bad = 0;
  logic [47:0] exp_q[$];

  snd_dma_seq #(.NCH(NCH), .AW(AW)) dut (
    .clk32     (clk32),
    .por       (por),
    .clk_en    (clk_en),
    .reg_wr    (reg_wr),
    .reg_ch    (reg_ch),
    .reg_sel   (reg_sel),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .sreq      (sreq),
    .bus_req   (bus_req),
    .bus_gnt   (bus_gnt),
    .bus_addr  (bus_addr),
    .bus_ch    (bus_ch),
    .sint      (sint),
    .active    (active)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk32 = 1'b0;
    forever #5 clk32 = ~clk32;
  end

  task automatic clear_inputs();
    clk_en = 1'b1; reg_wr = 1'b0; reg_ch = '0; reg_sel = 2'd0;
    reg_wdata = '0; sreq = '0; bus_gnt = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk32);
    por = 1'b1;
    clear_inputs();
    @(negedge clk32);
    @(negedge clk32);
    por = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk32);
    @(negedge clk32);
  endtask

  task automatic wr_reg(input int c, input int s, input int d);
    reg_wr = 1'b1; reg_ch = CW'(c); reg_sel = 2'(s); reg_wdata = AW'(d);
    step();
    reg_wr = 1'b0;
  endtask

  task automatic rd(input int c, input int s, output logic [AW-1:0] v);
    reg_ch = CW'(c); reg_sel = 2'(s);
    #1;
    v = reg_rdata;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic          m_en   [NCH];
  logic          m_rpt  [NCH];
  logic          m_act  [NCH];
  logic [AW-1:0] m_base [NCH];
  logic [AW-1:0] m_top  [NCH];
  logic [AW-1:0] m_cur  [NCH];
  logic [NCH-1:0] m_sint;
  bit            m_busy;
  int            m_owner;
  int            m_last;

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_en[i] = 0; m_rpt[i] = 0; m_act[i] = 0;
      m_base[i] = '0; m_top[i] = '0; m_cur[i] = '0;
    end
    m_sint = '0; m_busy = 0; m_owner = 0; m_last = NCH - 1;
  endtask

  function automatic logic [AW-1:0] m_rd(input int c, input int s);
    case (s)
      0:       return AW'({m_rpt[c], m_en[c]});
      1:       return m_base[c];
      2:       return m_top[c];
      default: return m_cur[c];
    endcase
  endfunction

  // Applies one clock edge worth of the specified register/transfer rules.
  task automatic model_step();
    logic          n_en[NCH], n_rpt[NCH], n_act[NCH];
    logic [AW-1:0] n_base[NCH], n_top[NCH], n_cur[NCH];
    logic [NCH-1:0] n_sint;
    bit grant, fe, ctl_same, found, n_busy;
    int g, c, cc, n_owner, n_last;
    n_en = m_en; n_rpt = m_rpt; n_act = m_act;
    n_base = m_base; n_top = m_top; n_cur = m_cur;
    n_sint = '0; n_busy = m_busy; n_owner = m_owner; n_last = m_last;
    grant = m_busy && bus_gnt;
    g = m_owner;
    c = int'(reg_ch);
    ctl_same = reg_wr && (reg_sel == 2'd0) && (c == g);
    if (grant) begin
      fe = (longint'(m_cur[g]) + 1) >= longint'(m_top[g]);
      n_sint[g] = fe;
      if (!ctl_same) begin
        if (fe && m_rpt[g]) n_cur[g] = m_base[g];
        else n_cur[g] = m_cur[g] + 1'b1;
        if (fe && !m_rpt[g]) begin n_en[g] = 0; n_act[g] = 0; end
        if (!m_en[g]) n_act[g] = 0;
      end
    end
    if (reg_wr) begin
      case (reg_sel)
        2'd0: begin
          n_en[c] = reg_wdata[0]; n_rpt[c] = reg_wdata[1];
          if (reg_wdata[0]) begin
            n_cur[c] = m_base[c]; n_act[c] = 1;
          end else if (!(m_busy && m_owner == c) || grant) begin
            n_act[c] = 0;
          end
        end
        2'd1: n_base[c] = reg_wdata;
        2'd2: n_top[c] = reg_wdata;
        default: ;
      endcase
    end
    if (grant) begin
      n_busy = 0; n_last = g;
    end else if (!m_busy && clk_en) begin
      found = 0;
      for (int k = 1; k <= NCH; k++) begin
        cc = (m_last + k) % NCH;
        if (!found && m_act[cc] && sreq[cc] &&
            !(reg_wr && reg_sel == 2'd0 && c == cc && !reg_wdata[0])) begin
          found = 1; n_busy = 1; n_owner = cc;
        end
      end
    end
    m_en = n_en; m_rpt = n_rpt; m_act = n_act;
    m_base = n_base; m_top = n_top; m_cur = n_cur;
    m_sint = n_sint; m_busy = n_busy; m_owner = n_owner; m_last = n_last;
  endtask

  function automatic logic [47:0] m_expect();
    logic [NCH-1:0] act;
    for (int i = 0; i < NCH; i++) act[i] = m_act[i];
    return {m_busy ? 1'b1 : 1'b0, m_busy ? m_cur[m_owner] : 21'h0,
            m_busy ? 1'(m_owner) : 1'b0, act, m_sint,
            m_rd(int'(reg_ch), int'(reg_sel))};
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic          wr;
    logic [CW-1:0] ch;
    logic [1:0]    sel;
    logic [AW-1:0] wd;
    logic [1:0]    sq;
    logic          en;
    logic          gnt;
    logic [47:0]   exp;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(int wr, int ch, int sel, int wd, int sq, int en, int gnt,
                              int req, int addr, int bch, int act, int si, int rdv);
    vec_t v;
    v.wr = 1'(wr); v.ch = CW'(ch); v.sel = 2'(sel); v.wd = AW'(wd);
    v.sq = 2'(sq); v.en = 1'(en); v.gnt = 1'(gnt);
    v.exp = {1'(req), 21'(addr), 1'(bch), 2'(act), 2'(si), 21'(rdv)};
    tbl.push_back(v);
  endfunction

  logic [AW-1:0] v_rd;

  initial begin
    por = 1'b1;
    clear_inputs();

    // Reset state of every register.
    do_reset();
    chk("rst_out", {bus_req, bus_addr, bus_ch, active, sint}, '0);
    for (int c = 0; c < NCH; c++)
      for (int s = 0; s < 4; s++) begin
        rd(c, s, v_rd);
        chk("rst_reg", v_rd, '0);
      end

    // Single-word frames, one-shot stop, round-robin.
    add(1,0,1,'h100,0,1,0, 0,0,0,0,0,'h100);
    add(1,0,2,'h103,0,1,0, 0,0,0,0,0,'h103);
    add(1,0,0,3,0,1,0,     0,0,0,1,0,3);
    add(0,0,3,0,1,1,0,     1,'h100,0,1,0,'h100);
    add(0,0,3,0,1,1,1,     0,0,0,1,0,'h101);
    add(0,0,3,0,1,1,0,     1,'h101,0,1,0,'h101);
    add(0,0,3,0,1,1,1,     0,0,0,1,0,'h102);
    add(0,0,3,0,1,1,0,     1,'h102,0,1,0,'h102);
    add(0,0,3,0,1,1,1,     0,0,0,1,1,'h100);
    add(0,0,3,0,1,1,0,     1,'h100,0,1,0,'h100);
    add(0,0,3,0,1,1,1,     0,0,0,1,0,'h101);
    add(1,1,1,'h10,0,1,0,  0,0,0,1,0,'h10);
    add(1,1,2,'h12,0,1,0,  0,0,0,1,0,'h12);
    add(1,1,0,1,0,1,0,     0,0,0,3,0,1);
    add(0,1,3,0,2,1,0,     1,'h10,1,3,0,'h10);
    add(0,1,3,0,2,1,1,     0,0,0,3,0,'h11);
    add(0,1,3,0,2,1,0,     1,'h11,1,3,0,'h11);
    add(0,1,3,0,2,1,1,     0,0,0,1,2,'h12);
    add(0,1,0,0,2,1,0,     0,0,0,1,0,0);
    add(0,1,3,0,2,1,0,     0,0,0,1,0,'h12);
    add(1,1,0,3,0,1,0,     0,0,0,3,0,3);
    add(0,0,3,0,3,1,0,     1,'h101,0,3,0,'h101);
    add(0,0,3,0,3,1,1,     0,0,0,3,0,'h102);
    add(0,1,3,0,3,1,0,     1,'h10,1,3,0,'h10);
    add(0,1,3,0,3,1,1,     0,0,0,3,0,'h11);
    add(0,0,3,0,3,1,0,     1,'h102,0,3,0,'h102);
    add(0,0,3,0,3,1,1,     0,0,0,3,1,'h100);
    add(0,1,3,0,3,1,0,     1,'h11,1,3,0,'h11);
    add(0,1,3,0,3,1,1,     0,0,0,3,2,'h10);
    add(0,1,3,0,2,0,0,     0,0,0,3,0,'h10);
    add(0,1,3,0,2,1,0,     1,'h10,1,3,0,'h10);
    add(0,1,3,0,2,1,1,     0,0,0,3,0,'h11);
    add(0,1,3,0,2,0,0,     0,0,0,3,0,'h11);
    add(0,1,3,0,2,1,0,     1,'h11,1,3,0,'h11);
    add(0,1,3,0,2,1,1,     0,0,0,3,2,'h10);

    foreach (tbl[i]) begin
      reg_wr = tbl[i].wr; reg_ch = tbl[i].ch; reg_sel = tbl[i].sel;
      reg_wdata = tbl[i].wd; sreq = tbl[i].sq; clk_en = tbl[i].en;
      bus_gnt = tbl[i].gnt;
      step();
      chk($sformatf("table[%0d]", i),
          {bus_req, bus_addr, bus_ch, active, sint, reg_rdata}, tbl[i].exp);
    end

    // Disable while owning the bus.
    do_reset();
    wr_reg(0, 1, 'h20); wr_reg(0, 2, 'h30); wr_reg(0, 0, 1);
    sreq = 2'b01;
    step();
    chk("dis_req", {bus_req, bus_addr}, {1'b1, 21'h20});
    wr_reg(0, 0, 0);
    chk("dis_hold", {bus_req, active[0]}, 2'b11);
    step(); step();
    chk("dis_wait", {bus_req, bus_addr}, {1'b1, 21'h20});
    bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0;
    chk("dis_gnt", {bus_req, active}, 3'b000);
    rd(0, 3, v_rd);
    chk("dis_cur", v_rd, 21'h21);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("dis_noreq", bus_req, 1'b0);
    end

    // Wrap and same-edge boundary cases.
    do_reset();
    wr_reg(0, 1, 'h1FFFFF); wr_reg(0, 2, 0); wr_reg(0, 0, 3);
    sreq = 2'b01;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wrap_addr", {bus_req, bus_addr}, {1'b1, 21'h1FFFFF});
      bus_gnt = 1'b1;
      step();
      bus_gnt = 1'b0;
      chk("wrap_sint", {bus_req, sint}, 3'b001);
    end
    step();
    bus_gnt = 1'b1;
    wr_reg(0, 0, 3);
    bus_gnt = 1'b0;
    chk("same_fe", {sint, active}, 4'b0101);
    rd(0, 3, v_rd);
    chk("same_fe_cur", v_rd, 21'h1FFFFF);
    wr_reg(0, 0, 1);
    chk("oneshot_req", {bus_req, bus_addr}, {1'b1, 21'h1FFFFF});
    bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0;
    chk("oneshot_end", {sint, active}, 4'b0100);
    rd(0, 3, v_rd);
    chk("oneshot_cur", v_rd, 21'h0);
    sreq = 2'b00;
    wr_reg(1, 1, 'h40); wr_reg(1, 2, 'h50); wr_reg(1, 0, 1);
    sreq = 2'b10;
    step();
    chk("same_req", {bus_req, bus_addr, bus_ch}, {1'b1, 21'h40, 1'b1});
    bus_gnt = 1'b1;
    wr_reg(1, 0, 1);
    bus_gnt = 1'b0;
    chk("same_nofe", {sint, active}, 4'b0010);
    rd(1, 3, v_rd);
    chk("same_cur", v_rd, 21'h40);

    // Reset in the middle of a transfer.
    do_reset();
    wr_reg(0, 1, 'h55); wr_reg(0, 2, 'h60); wr_reg(0, 0, 1);
    sreq = 2'b01;
    step();
    chk("rst_pre", bus_req, 1'b1);
    #2 por = 1'b1;
    #1 chk("rst_async", {bus_req, bus_addr, active}, '0);
    @(negedge clk32);
    por = 1'b0;
    for (int c = 0; c < NCH; c++)
      for (int s = 0; s < 4; s++) begin
        rd(c, s, v_rd);
        chk("rst_mid_reg", v_rd, '0);
      end
    bus_gnt = 1'b1; sreq = 2'b11;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_late_gnt", {bus_req, active, sint}, '0);
    end
    rd(0, 3, v_rd);
    chk("rst_late_cur", v_rd, '0);

    // Random traffic against the model.
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reg_wr  = ($urandom_range(0, 5) == 0);
      reg_ch  = CW'($urandom_range(0, NCH - 1));
      reg_sel = 2'($urandom_range(0, 3));
      case (reg_sel)
        2'd0:    reg_wdata = AW'($urandom_range(0, 3));
        2'd1:    reg_wdata = ($urandom_range(0, 15) == 0) ? 21'h1FFFFF : AW'($urandom_range(0, 24));
        2'd2:    reg_wdata = ($urandom_range(0, 15) == 0) ? 21'h0 : AW'($urandom_range(0, 32));
        default: reg_wdata = AW'($urandom);
      endcase
      sreq    = NCH'($urandom_range(0, 3));
      clk_en  = ($urandom_range(0, 2) == 0);
      bus_gnt = $urandom_range(0, 1);
      model_step();
      exp_q.push_back(m_expect());
      step();
      chk($sformatf("rand[%0d]", cyc),
          {bus_req, bus_addr, bus_ch, active, sint, reg_rdata}, exp_q.pop_front());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
